stream_traffic_generator: RTL and testbench

STREAM_TRAFFIC_GENERATOR -- requirements
Module: stream_traffic_generator

---
 rtl/stream_traffic_generator.sv | 165 ++++++++++++++++
 tb/tb_stream_traffic_generator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_traffic_generator.sv
// AXI-Stream traffic generator: emits N beats (or an endless stream when N=0)
// of a selectable data pattern, with an optional idle gap after each beat,
// TLAST framing every PACKET_LEN beats and an accepted-beat counter.
//
// state | meaning
// IDLE  | after reset, waiting for a start edge
// SEND  | beat presented on the stream, waiting for acceptance
// GAP   | idle cycles between beats, TVALID low
// DONE  | run finished or stopped, done high until the next start
module stream_traffic_generator #(
    parameter int unsigned PACKET_LEN = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_ACE1
) (
    input  logic         aclk,
    input  logic         resetn,
    input  logic [31:0]  command,
    output logic         M00_AXIS_TVALID,
    output logic [127:0] M00_AXIS_TDATA,
    output logic         M00_AXIS_TLAST,
    input  logic         M00_AXIS_TREADY,
    output logic [31:0]  sent_count,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    localparam logic [15:0] PLEN = 16'(PACKET_LEN);

    state_t      state;
    logic        start_q;
    logic        stop_seen;
    logic [1:0]  pattern;
    logic [7:0]  gap_len;
    logic [7:0]  gap_cnt;
    logic [15:0] beat_total;
    logic [31:0] idx;       // 0-based index of the beat currently presented
    logic [15:0] pkt_pos;   // 1-based position of that beat inside its packet
    logic [31:0] lfsr;

    logic        start_evt;
    logic        accept;
    logic        stop_now;
    logic        last_beat;
    logic [31:0] nxt_idx;
    logic [15:0] nxt_pos;
    logic [31:0] nxt_lfsr;
    logic        nxt_last;
    logic        unused_bits;

    // Galois LFSR, polynomial x^32+x^22+x^2+x+1, right-shifting
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [127:0] beat_data(input logic [1:0] pat,
                                               input logic [31:0] i,
                                               input logic [31:0] l);
        case (pat)
            2'b00:   return {4{i}};
            2'b01:   return {4{l}};
            2'b10:   return {128{1'b1}};
            default: return 128'd0;
        endcase
    endfunction

    assign unused_bits = ^command[27:24];

    assign start_evt = command[31] & ~start_q & ~command[30] &
                       ((state == IDLE) || (state == DONE));
    assign accept    = M00_AXIS_TVALID & M00_AXIS_TREADY;
    assign stop_now  = command[30] | stop_seen;
    assign nxt_idx   = idx + 32'd1;
    assign nxt_pos   = (pkt_pos == PLEN) ? 16'd1 : pkt_pos + 16'd1;
    assign nxt_lfsr  = lfsr_step(lfsr);
    assign last_beat = (beat_total != 16'd0) && (nxt_idx == {16'h0000, beat_total});
    assign nxt_last  = (nxt_pos == PLEN) ||
                       ((beat_total != 16'd0) && ((nxt_idx + 32'd1) == {16'h0000, beat_total}));

    // Sequencer: start/stop handling, beat generation and registered outputs
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            start_q         <= 1'b1;
            stop_seen       <= 1'b0;
            pattern         <= 2'b00;
            gap_len         <= 8'd0;
            gap_cnt         <= 8'd0;
            beat_total      <= 16'd0;
            idx             <= 32'd0;
            pkt_pos         <= 16'd1;
            lfsr            <= LFSR_SEED;
            M00_AXIS_TVALID <= 1'b0;
            M00_AXIS_TDATA  <= 128'd0;
            M00_AXIS_TLAST  <= 1'b0;
            sent_count      <= 32'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            start_q <= command[31];
            case (state)
                IDLE, DONE: begin
                    if (start_evt) begin
                        state           <= SEND;
                        pattern         <= command[29:28];
                        gap_len         <= command[23:16];
                        beat_total      <= command[15:0];
                        stop_seen       <= 1'b0;
                        idx             <= 32'd0;
                        pkt_pos         <= 16'd1;
                        lfsr            <= LFSR_SEED;
                        sent_count      <= 32'd0;
                        M00_AXIS_TVALID <= 1'b1;
                        M00_AXIS_TDATA  <= beat_data(command[29:28], 32'd0, LFSR_SEED);
                        M00_AXIS_TLAST  <= (PLEN == 16'd1) || (command[15:0] == 16'd1);
                        busy            <= 1'b1;
                        done            <= 1'b0;
                    end
                end
                SEND: begin
                    if (command[30]) begin
                        stop_seen <= 1'b1;
                    end
                    if (accept) begin
                        if (sent_count != 32'hFFFF_FFFF) begin
                            sent_count <= sent_count + 32'd1;
                        end
                        if (stop_now || last_beat) begin
                            state           <= DONE;
                            M00_AXIS_TVALID <= 1'b0;
                            M00_AXIS_TLAST  <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                        end else begin
                            idx            <= nxt_idx;
                            pkt_pos        <= nxt_pos;
                            lfsr           <= nxt_lfsr;
                            M00_AXIS_TDATA <= beat_data(pattern, nxt_idx, nxt_lfsr);
                            M00_AXIS_TLAST <= nxt_last;
                            if (gap_len != 8'd0) begin
                                state           <= GAP;
                                gap_cnt         <= gap_len;
                                M00_AXIS_TVALID <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (command[30]) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (gap_cnt == 8'd1) begin
                        state           <= SEND;
                        M00_AXIS_TVALID <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_traffic_generator.sv
// Bench for stream_traffic_generator: a scoreboard of expected beats built
// from the pattern/framing rules, a monitor comparing every accepted beat,
// and directed plus randomized runs.
module tb_stream_traffic_generator;

    localparam int          PL   = 4;
    localparam logic [31:0] SEED = 32'hACE1_ACE1;

    typedef struct {
        logic [127:0] d;
        logic         l;
    } beat_t;

    logic         aclk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  command = 32'd0;
    logic         tvalid;
    logic [127:0] tdata;
    logic         tlast;
    logic         tready = 1'b1;
    logic [31:0]  sent_count;
    logic         busy;
    logic         done;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    acc_count = 0;
    int    acc_cyc[$];
    int    rdy_mode = 0;
    beat_t exp_q[$];

    stream_traffic_generator #(.PACKET_LEN(PL), .LFSR_SEED(SEED)) dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .command         (command),
        .M00_AXIS_TVALID (tvalid),
        .M00_AXIS_TDATA  (tdata),
        .M00_AXIS_TLAST  (tlast),
        .M00_AXIS_TREADY (tready),
        .sent_count      (sent_count),
        .busy            (busy),
        .done            (done)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference LFSR: divide by x^32+x^22+x^2+x+1, taps at bit positions 31,21,1,0
    function automatic logic [31:0] ref_lfsr_next(input logic [31:0] s);
        logic [31:0] fb;
        fb = s[0] ? ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1) : 32'h0;
        return (s >> 1) ^ fb;
    endfunction

    task automatic push_expected(input int pat, input int n);
        int          cnt;
        logic [31:0] l;
        logic [31:0] k32;
        beat_t       b;
        cnt = (n == 0) ? 64 : n;
        l = SEED;
        for (int k = 0; k < cnt; k++) begin
            k32 = 32'(k);
            case (pat)
                0:       b.d = {k32, k32, k32, k32};
                1:       b.d = {l, l, l, l};
                2:       b.d = ~128'd0;
                default: b.d = 128'd0;
            endcase
            b.l = (((k + 1) % PL) == 0) || ((n != 0) && (k + 1 == n));
            exp_q.push_back(b);
            l = ref_lfsr_next(l);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic start_run(input int pat, input int g, input int n, output int start_c);
        command = {2'b00, 2'(pat), 4'b0000, 8'(g), 16'(n)};
        tick();
        command[31] = 1'b1;
        start_c = cyc;
        tick();
        command[31] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 3000) begin
            tick();
            t++;
        end
        check(name, 128'(done), 128'd1);
    endtask

    task automatic wait_accepts(input int base, input int cnt);
        int t;
        t = 0;
        while ((acc_count - base) < cnt && t < 500) begin
            tick();
            t++;
        end
        check("accept_wait", 128'((acc_count - base) >= cnt), 128'd1);
    endtask

    task automatic run_test(input int pat, input int g, input int n, input int mode,
                            output int base, output int sc);
        rdy_mode = mode;
        push_expected(pat, n);
        base = acc_count;
        start_run(pat, g, n, sc);
        wait_done("run_done");
        check("tvalid_after_done", 128'(tvalid), 128'd0);
        check("busy_after_done", 128'(busy), 128'd0);
        check("sent_count", 128'(sent_count), 128'(n));
        check("accepted_beats", 128'(acc_count - base), 128'(n));
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        if (mode == 0 && (acc_count - base) == n) begin
            check("first_beat_latency", 128'(acc_cyc[base]), 128'(sc + 1));
            for (int i = 1; i < n; i++)
                check("beat_spacing", 128'(acc_cyc[base + i] - acc_cyc[base + i - 1]), 128'(g + 1));
        end
        exp_q.delete();
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = hold low 5 cycles once TVALID rises
    initial begin
        int held;
        held = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 2) begin
                if (tvalid && held < 5) begin
                    tready = 1'b0;
                    held++;
                end else begin
                    tready = 1'b1;
                end
            end else begin
                held = 0;
                tready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: hold-stability of stalled beats and scoreboard compare of accepted ones
    initial begin
        logic         pv;
        logic [127:0] pd;
        logic         pl;
        beat_t        e;
        pv = 1'b0;
        pd = 128'd0;
        pl = 1'b0;
        forever begin
            @(negedge aclk);
            if (!resetn) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    check("stall_valid_held", 128'(tvalid), 128'd1);
                    check("stall_data_held", tdata, pd);
                    check("stall_last_held", 128'(tlast), 128'(pl));
                end
                if (tvalid && tready) begin
                    acc_count++;
                    acc_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h with nothing expected", tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", tdata, e.d);
                        check("beat_last", 128'(tlast), 128'(e.l));
                    end
                    pv = 1'b0;
                end else begin
                    pv = tvalid;
                    pd = tdata;
                    pl = tlast;
                end
            end
        end
    end

    initial begin
        int base;
        int sc;
        int pat;
        int g;
        int n;
        int got;

        resetn = 1'b0;
        command = 32'd0;
        tick(3);
        check("reset_tvalid", 128'(tvalid), 128'd0);
        check("reset_tdata", tdata, 128'd0);
        check("reset_tlast", 128'(tlast), 128'd0);
        check("reset_sent_count", 128'(sent_count), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        resetn = 1'b1;
        tick(2);

        // 4 beats back to back, counting pattern
        run_test(0, 0, 4, 0, base, sc);
        // gap of two idle cycles between beats
        run_test(0, 2, 3, 0, base, sc);
        // LFSR pattern with a 5-cycle stall on the first beat
        run_test(1, 0, 2, 2, base, sc);
        if ((acc_count - base) == 2)
            check("stalled_accept_cycle", 128'(acc_cyc[base]), 128'(sc + 6));

        // randomized runs with random backpressure
        for (int r = 0; r < 10; r++) begin
            pat = int'($urandom_range(0, 3));
            g   = int'($urandom_range(0, 3));
            n   = int'($urandom_range(1, 11));
            run_test(pat, g, n, 1, base, sc);
        end

        // endless stream stopped after 10 beats
        rdy_mode = 0;
        push_expected(0, 0);
        base = acc_count;
        start_run(0, 0, 0, sc);
        wait_accepts(base, 10);
        command[30] = 1'b1;
        wait_done("stop_send_done");
        command[30] = 1'b0;
        got = acc_count - base;
        check("stop_sent_matches", 128'(sent_count), 128'(got));
        check("stop_count_range", 128'(got >= 10 && got <= 12), 128'd1);
        check("stop_tvalid_low", 128'(tvalid), 128'd0);
        exp_q.delete();

        // stop while in a gap: DONE on the next edge
        push_expected(2, 0);
        base = acc_count;
        start_run(2, 5, 0, sc);
        wait_accepts(base, 2);
        tick(2);
        command[30] = 1'b1;
        tick();
        check("stop_gap_done", 128'(done), 128'd1);
        check("stop_gap_busy", 128'(busy), 128'd0);
        check("stop_gap_sent", 128'(sent_count), 128'd2);
        command[30] = 1'b0;
        exp_q.delete();

        // asynchronous reset mid-transfer while start is held high
        push_expected(0, 0);
        base = acc_count;
        command = 32'd0;
        tick();
        command[31] = 1'b1;
        wait_accepts(base, 3);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_tvalid", 128'(tvalid), 128'd0);
        check("async_rst_tdata", tdata, 128'd0);
        check("async_rst_tlast", 128'(tlast), 128'd0);
        check("async_rst_sent", 128'(sent_count), 128'd0);
        check("async_rst_busy", 128'(busy), 128'd0);
        check("async_rst_done", 128'(done), 128'd0);
        tick(2);
        resetn = 1'b1;
        exp_q.delete();
        base = acc_count;
        tick(10);
        check("no_restart_busy", 128'(busy), 128'd0);
        check("no_restart_tvalid", 128'(tvalid), 128'd0);
        check("no_restart_beats", 128'(acc_count - base), 128'd0);

        // start and stop in the same cycle are ignored
        command = 32'd0;
        tick();
        command = 32'hC000_0004;
        tick(5);
        check("start_stop_busy", 128'(busy), 128'd0);
        check("start_stop_tvalid", 128'(tvalid), 128'd0);
        check("start_stop_done", 128'(done), 128'd0);
        command[30] = 1'b0;
        tick(3);
        check("held_start_no_edge", 128'(busy), 128'd0);
        command = 32'd0;
        tick();

        // a fresh edge starts normally after all of the above
        run_test(3, 1, 5, 0, base, sc);
        run_test(1, 0, 9, 0, base, sc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
